// File: rtl/fx3_rpath_feeder_if.sv
// Stream-in and ping-pong read-side FIFO signals of the FX3 read path feeder.
// master is the feeder itself; slave is whatever drives the stream and models the bus.
interface fx3_rpath_feeder_if;
  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic [1:0]  i_rpath_ready;
  logic [1:0]  o_rpath_activate;
  logic [23:0] i_rpath_size;
  logic [31:0] o_rpath_data;
  logic        o_rpath_strobe;
  logic        o_idle;
  logic [31:0] o_packet_count;

  modport master (
    input  i_data, i_valid, i_flush, i_rpath_ready, i_rpath_size,
    output o_ready, o_rpath_activate, o_rpath_data, o_rpath_strobe, o_idle, o_packet_count
  );

  modport slave (
    output i_data, i_valid, i_flush, i_rpath_ready, i_rpath_size,
    input  o_ready, o_rpath_activate, o_rpath_data, o_rpath_strobe, o_idle, o_packet_count
  );
endinterface

// File: rtl/fx3_rpath_feeder.sv
// Packs a valid/ready word stream into the FX3 dual ping-pong read buffers,
// alternating buffers and closing short packets on flush or inactivity timeout.
module fx3_rpath_feeder #(
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  fx3_rpath_feeder_if.master  f
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               act;
  logic                     last_ch;
  logic                     first;
  logic [23:0]              cnt, cnt_nxt, size_r, size_eff;
  logic [TIMEOUT_WIDTH-1:0] tmo;
  logic [31:0]              data_p1;
  logic                     vld_p1;
  logic [31:0]              pkt_cnt;
  logic                     ready, xfer, start, close;
  logic [1:0]               pick;

  // The buffer size is only valid once activate is up, so the first WRITE
  // cycle uses it directly while it is being latched.
  always_comb begin
    size_eff = first ? f.i_rpath_size : size_r;
    ready    = (state == S_WRITE) && (cnt < size_eff);
    xfer     = ready && f.i_valid;
    cnt_nxt  = cnt + {23'd0, xfer};
    start    = (state == S_IDLE) && f.i_valid && (f.i_rpath_ready != 2'b00);
    if (&f.i_rpath_ready) pick = last_ch ? 2'b01 : 2'b10;
    else                  pick = f.i_rpath_ready;
    close    = (state == S_WRITE) &&
               ((cnt_nxt >= size_eff) ||
                (f.i_flush && (cnt_nxt != '0)) ||
                (TO_EN && (tmo == TO_LAST) && (cnt != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_WRITE;
      S_WRITE:   if (close) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    f.o_ready          = ready;
    f.o_rpath_activate = act;
    f.o_rpath_data     = data_p1;
    f.o_rpath_strobe   = vld_p1;
    f.o_idle           = (state == S_IDLE) && (act == 2'b00);
    f.o_packet_count   = pkt_cnt;
  end

  // p1: accepted word and its strobe, one cycle after the transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      act     <= 2'b00;
      last_ch <= 1'b1;
      first   <= 1'b0;
      cnt     <= '0;
      size_r  <= '0;
      tmo     <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) data_p1 <= f.i_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            act   <= pick;
            cnt   <= '0;
            tmo   <= '0;
            first <= 1'b1;
          end
        end
        S_WRITE: begin
          first <= 1'b0;
          if (first) size_r <= f.i_rpath_size;
          cnt <= cnt_nxt;
          if (xfer)            tmo <= '0;
          else if (tmo != '1)  tmo <= tmo + 1'b1;
        end
        S_RELEASE: begin
          act     <= 2'b00;
          last_ch <= act[1];
          pkt_cnt <= pkt_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx3_rpath_feeder.sv
// Directed bench for fx3_rpath_feeder: scoreboarded data path plus packet,
// channel, flush, timeout, reset and zero-size scenarios.
module tb_fx3_rpath_feeder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  fx3_rpath_feeder_if f0();
  fx3_rpath_feeder_if f1();

  fx3_rpath_feeder #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(16)) dut0 (.clk(clk), .rst(rst), .f(f0));
  fx3_rpath_feeder #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(0))  dut1 (.clk(clk), .rst(rst), .f(f1));

  assign f1.i_data        = f0.i_data;
  assign f1.i_valid       = f0.i_valid;
  assign f1.i_flush       = f0.i_flush;
  assign f1.i_rpath_ready = f0.i_rpath_ready;
  assign f1.i_rpath_size  = f0.i_rpath_size;

  always #5 clk = ~clk;

  logic [31:0] exq[$];
  logic [1:0]  chq[$];
  logic [1:0]  prev_act = 2'b00;
  int          stb = 0;
  int          act_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (f0.o_rpath_activate != 2'b00) act_cycles++;
    if (f0.o_rpath_activate != 2'b00 && prev_act == 2'b00) chq.push_back(f0.o_rpath_activate);
    prev_act = f0.o_rpath_activate;
    if (f0.o_rpath_strobe === 1'b1) begin
      stb++;
      chk("strobe_owned", {31'd0, f0.o_rpath_activate != 2'b00}, 32'd1);
      total++;
      assert (exq.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%0h expected=scoreboard entry", f0.o_rpath_data);
      end
      if (exq.size() != 0) chk("strobe_data", f0.o_rpath_data, exq.pop_front());
    end
    if (f0.i_valid === 1'b1 && f0.o_ready === 1'b1) exq.push_back(f0.i_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ch(input string tag, input logic [1:0] exp);
    total++;
    assert (chq.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=no packet expected=%0h", tag, exp);
    end
    if (chq.size() != 0) chk(tag, {30'd0, chq.pop_front()}, {30'd0, exp});
  endtask

  // Streams n words base..base+n-1 with continuous valid; optionally flush with the last.
  task automatic feed(input int n, input logic [31:0] base, input bit flush_last);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 500) begin
      f0.i_valid = 1'b1;
      f0.i_data  = base + sent;
      f0.i_flush = flush_last && (sent == n - 1);
      @(negedge clk);
      if (f0.o_ready) sent++;
      step();
      guard++;
    end
    f0.i_valid = 1'b0;
    f0.i_flush = 1'b0;
    chk("feed_done", sent, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exq.delete();
    chq.delete();
  endtask

  initial begin
    int s0, k, a0;
    logic [31:0] pc;
    rst = 1'b1;
    f0.i_data = '0; f0.i_valid = 1'b0; f0.i_flush = 1'b0;
    f0.i_rpath_ready = 2'b00; f0.i_rpath_size = 24'd4;
    repeat (3) step();
    chk("rst_activate", {30'd0, f0.o_rpath_activate}, 32'd0);
    chk("rst_strobe", {31'd0, f0.o_rpath_strobe}, 32'd0);
    chk("rst_data", f0.o_rpath_data, 32'd0);
    chk("rst_ready", {31'd0, f0.o_ready}, 32'd0);
    chk("rst_count", f0.o_packet_count, 32'd0);
    chk("rst_idle", {31'd0, f0.o_idle}, 32'd1);
    rst = 1'b0;
    step();

    // single full packet of 4
    f0.i_rpath_ready = 2'b11; f0.i_rpath_size = 24'd4; s0 = stb;
    feed(4, 32'h100, 1'b0);
    chk("t1_ready_low", {31'd0, f0.o_ready}, 32'd0);
    chk("t1_act_last_strobe", {30'd0, f0.o_rpath_activate}, 32'd1);
    step();
    chk("t1_act_drop", {30'd0, f0.o_rpath_activate}, 32'd0);
    chk("t1_pc", f0.o_packet_count, 32'd1);
    chk("t1_strobes", stb - s0, 32'd4);
    chk_ch("t1_ch", 2'b01);

    // ping-pong across both buffers, then only buffer 0 available
    do_reset();
    feed(8, 32'h200, 1'b0);
    step();
    chk("t2_pc", f0.o_packet_count, 32'd2);
    chk_ch("t2_ch_a", 2'b01);
    chk_ch("t2_ch_b", 2'b10);
    f0.i_rpath_ready = 2'b01;
    feed(8, 32'h300, 1'b0);
    step();
    chk("t2_pc_b", f0.o_packet_count, 32'd4);
    chk_ch("t2_ch_c", 2'b01);
    chk_ch("t2_ch_d", 2'b01);

    // flush together with the 5th accepted word
    f0.i_rpath_ready = 2'b11; f0.i_rpath_size = 24'd128; s0 = stb;
    feed(5, 32'h400, 1'b1);
    chk("t3_ready_low", {31'd0, f0.o_ready}, 32'd0);
    step();
    chk("t3_act_drop", {30'd0, f0.o_rpath_activate}, 32'd0);
    chk("t3_pc", f0.o_packet_count, 32'd5);
    chk("t3_strobes", stb - s0, 32'd5);
    chk_ch("t3_ch", 2'b10);

    // inactivity timeout of 16 cycles; dut1 has timeout disabled
    s0 = stb;
    feed(3, 32'h500, 1'b0);
    k = 1;
    while (f0.o_rpath_activate != 2'b00 && k < 100) begin
      step();
      k++;
    end
    chk("t4_release_cycle", k, 32'd18);
    chk("t4_strobes", stb - s0, 32'd3);
    chk("t4_pc", f0.o_packet_count, 32'd6);
    chk_ch("t4_ch", 2'b01);
    repeat (40) step();
    chk("t4_hold_act", {30'd0, f1.o_rpath_activate}, 32'd1);
    chk("t4_hold_idle", {31'd0, f1.o_idle}, 32'd0);
    a0 = act_cycles; pc = f0.o_packet_count;
    f0.i_flush = 1'b1;
    step();
    f0.i_flush = 1'b0;
    repeat (2) step();
    chk("t4_flush_release", {30'd0, f1.o_rpath_activate}, 32'd0);
    chk("idle_flush_act", act_cycles - a0, 32'd0);
    chk("idle_flush_pc", f0.o_packet_count, pc);
    chk("idle_flush_idle", {31'd0, f0.o_idle}, 32'd1);

    // reset in the middle of a packet on buffer 1
    do_reset();
    f0.i_rpath_ready = 2'b10; s0 = stb;
    feed(2, 32'h600, 1'b0);
    rst = 1'b1;
    step();
    chk("t5_strobes", stb - s0, 32'd2);
    chk("t5_act", {30'd0, f0.o_rpath_activate}, 32'd0);
    chk("t5_strobe", {31'd0, f0.o_rpath_strobe}, 32'd0);
    chk("t5_idle", {31'd0, f0.o_idle}, 32'd1);
    chk("t5_pc", f0.o_packet_count, 32'd0);
    rst = 1'b0;
    chk_ch("t5_ch_abandoned", 2'b10);
    f0.i_rpath_ready = 2'b11; f0.i_rpath_size = 24'd4;
    feed(4, 32'h700, 1'b0);
    step();
    chk_ch("t5_ch_restart", 2'b01);
    chk("t5_pc_after", f0.o_packet_count, 32'd1);

    // zero-size buffer
    f0.i_rpath_size = 24'd0; a0 = act_cycles; s0 = stb;
    f0.i_valid = 1'b1; f0.i_data = 32'hDEAD;
    step();
    f0.i_valid = 1'b0;
    repeat (4) step();
    chk("t6_act_cycles", act_cycles - a0, 32'd2);
    chk("t6_strobes", stb - s0, 32'd0);
    chk("t6_pc", f0.o_packet_count, 32'd2);
    chk_ch("t6_ch", 2'b10);

    // ready flags change while buffer 0 is owned
    f0.i_rpath_ready = 2'b01; f0.i_rpath_size = 24'd128; s0 = stb;
    feed(2, 32'h800, 1'b0);
    f0.i_rpath_ready = 2'b10;
    step();
    chk("t7_act_a", {30'd0, f0.o_rpath_activate}, 32'd1);
    f0.i_rpath_ready = 2'b00;
    feed(2, 32'h810, 1'b1);
    chk("t7_act_b", {30'd0, f0.o_rpath_activate}, 32'd1);
    step();
    chk("t7_act_drop", {30'd0, f0.o_rpath_activate}, 32'd0);
    chk("t7_pc", f0.o_packet_count, 32'd3);
    chk("t7_strobes", stb - s0, 32'd4);
    chk_ch("t7_ch", 2'b01);
    chk("sb_empty", exq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
